// File: rtl/rename_register_file_if.sv
// Rename register file bus: decode (rename/read) slots, commit slots and the
// sticky idle-commit error flag. Clock and reset stay plain ports on the block.
interface rename_register_file_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned COMMIT_W = 2
);
    localparam int unsigned RW = $clog2(NREG);

    logic [ISSUE_W-1:0]          dec_valid;
    logic [ISSUE_W-1:0]          dec_occupy_rd;
    logic [ISSUE_W*TAG_W-1:0]    dec_tag;
    logic [ISSUE_W*RW-1:0]       dec_rs1;
    logic [ISSUE_W*RW-1:0]       dec_rs2;
    logic [ISSUE_W*RW-1:0]       dec_rd;
    logic [ISSUE_W*XLEN-1:0]     dec_vj;
    logic [ISSUE_W*XLEN-1:0]     dec_vk;
    logic [ISSUE_W*TAG_W-1:0]    dec_qj;
    logic [ISSUE_W*TAG_W-1:0]    dec_qk;
    logic                        rob_rollback;
    logic [COMMIT_W-1:0]         cm_valid;
    logic [COMMIT_W*TAG_W-1:0]   cm_tag;
    logic [COMMIT_W*RW-1:0]      cm_rd;
    logic [COMMIT_W*XLEN-1:0]    cm_data;
    logic                        err_commit_idle;

    // Decode/ROB side drives requests and reads operands back
    modport master (
        output dec_valid, dec_occupy_rd, dec_tag, dec_rs1, dec_rs2, dec_rd,
        output rob_rollback, cm_valid, cm_tag, cm_rd, cm_data,
        input  dec_vj, dec_vk, dec_qj, dec_qk, err_commit_idle
    );

    // Register file side
    modport slave (
        input  dec_valid, dec_occupy_rd, dec_tag, dec_rs1, dec_rs2, dec_rd,
        input  rob_rollback, cm_valid, cm_tag, cm_rd, cm_data,
        output dec_vj, dec_vk, dec_qj, dec_qk, err_commit_idle
    );
endinterface

// File: rtl/rename_register_file.sv
// Rename register file: per architectural register a value, a busy bit and the
// ROB tag of the in-flight producer. Operand reads are combinational with
// intra-bundle forwarding; renames, commits and rollback update on posedge clk.
// Optional macro RRF_COMMIT_BYPASS_EN: a busy operand whose tag matches a
// same-cycle commit returns that commit's data instead of the tag.
module rename_register_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned COMMIT_W = 2
) (
    input logic                   clk,
    input logic                   rst,
    rename_register_file_if.slave bus
);
    localparam int unsigned RW = $clog2(NREG);

    logic [XLEN-1:0]  r_value [NREG];
    logic [TAG_W-1:0] r_tag   [NREG];
    logic [NREG-1:0]  r_busy;
    logic             r_err;

    logic [XLEN-1:0]  w_value_d [NREG];
    logic [TAG_W-1:0] w_tag_d   [NREG];
    logic [NREG-1:0]  w_busy_d;
    logic [NREG-1:0]  w_clear;
    logic             w_err_d;

    logic [ISSUE_W*XLEN-1:0]  w_vj, w_vk;
    logic [ISSUE_W*TAG_W-1:0] w_qj, w_qk;
    logic [RW-1:0]            w_rs;
    logic [XLEN-1:0]          w_v;
    logic [TAG_W-1:0]         w_q;

    // Operand lookup: table (or commit bypass), then older-slot forwarding on top
    always_comb begin
        w_vj = '0;
        w_vk = '0;
        w_qj = '0;
        w_qk = '0;
        w_rs = '0;
        w_v  = '0;
        w_q  = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            for (int op = 0; op < 2; op++) begin
                w_rs = (op == 0) ? bus.dec_rs1[j*RW +: RW] : bus.dec_rs2[j*RW +: RW];
                w_v  = '0;
                w_q  = '0;
                if (w_rs != '0) begin
                    if (r_busy[w_rs]) begin
                        w_q = r_tag[w_rs];
`ifdef RRF_COMMIT_BYPASS_EN
                        // Youngest matching commit wins
                        for (int k = 0; k < COMMIT_W; k++) begin
                            if (bus.cm_valid[k] &&
                                bus.cm_tag[k*TAG_W +: TAG_W] == r_tag[w_rs]) begin
                                w_v = bus.cm_data[k*XLEN +: XLEN];
                                w_q = '0;
                            end
                        end
`endif
                    end else begin
                        w_v = r_value[w_rs];
                    end
                    // Youngest older slot renaming this register overrides everything
                    for (int i = 0; i < j; i++) begin
                        if (bus.dec_valid[i] && bus.dec_occupy_rd[i] &&
                            bus.dec_rd[i*RW +: RW] == w_rs) begin
                            w_v = '0;
                            w_q = bus.dec_tag[i*TAG_W +: TAG_W];
                        end
                    end
                end
                if (op == 0) begin
                    w_vj[j*XLEN +: XLEN]   = w_v;
                    w_qj[j*TAG_W +: TAG_W] = w_q;
                end else begin
                    w_vk[j*XLEN +: XLEN]   = w_v;
                    w_qk[j*TAG_W +: TAG_W] = w_q;
                end
            end
        end
    end

    assign bus.dec_vj          = w_vj;
    assign bus.dec_vk          = w_vk;
    assign bus.dec_qj          = w_qj;
    assign bus.dec_qk          = w_qk;
    assign bus.err_commit_idle = r_err;

    // Next state: rollback, else commits (data + tag-matched clear) then renames
    always_comb begin
        w_value_d = r_value;
        w_tag_d   = r_tag;
        w_busy_d  = r_busy;
        w_err_d   = r_err;
        w_clear   = '0;
        if (bus.rob_rollback) begin
            w_busy_d = '0;
            for (int r = 0; r < NREG; r++) begin
                w_tag_d[r] = '0;
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (bus.cm_valid[k] && bus.cm_rd[k*RW +: RW] != '0) begin
                    if (r_busy[bus.cm_rd[k*RW +: RW]]) begin
                        w_value_d[bus.cm_rd[k*RW +: RW]] = bus.cm_data[k*XLEN +: XLEN];
                        if (r_tag[bus.cm_rd[k*RW +: RW]] == bus.cm_tag[k*TAG_W +: TAG_W]) begin
                            w_clear[bus.cm_rd[k*RW +: RW]] = 1'b1;
                        end
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            for (int r = 0; r < NREG; r++) begin
                if (w_clear[r]) begin
                    w_busy_d[r] = 1'b0;
                    w_tag_d[r]  = '0;
                end
            end
            // Renames applied last so a same-cycle rename keeps the register busy
            for (int j = 0; j < ISSUE_W; j++) begin
                if (bus.dec_valid[j] && bus.dec_occupy_rd[j] && bus.dec_rd[j*RW +: RW] != '0) begin
                    w_busy_d[bus.dec_rd[j*RW +: RW]] = 1'b1;
                    w_tag_d[bus.dec_rd[j*RW +: RW]]  = bus.dec_tag[j*TAG_W +: TAG_W];
                end
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                r_value[r] <= '0;
                r_tag[r]   <= '0;
            end
        end else begin
            r_busy <= w_busy_d;
            r_err  <= w_err_d;
            for (int r = 0; r < NREG; r++) begin
                r_value[r] <= w_value_d[r];
                r_tag[r]   <= w_tag_d[r];
            end
        end
    end
endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus random
// traffic compared against a register-by-register behavioural model.
module tb_rename_register_file;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned ISSUE_W  = 2;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned RW       = $clog2(NREG);

    logic clk;
    logic rst;

    rename_register_file_if #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W)
    ) bus ();

    rename_register_file #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus per slot
    logic             t_dv  [ISSUE_W];
    logic             t_occ [ISSUE_W];
    logic [RW-1:0]    t_rs1 [ISSUE_W];
    logic [RW-1:0]    t_rs2 [ISSUE_W];
    logic [RW-1:0]    t_rd  [ISSUE_W];
    logic [TAG_W-1:0] t_tag [ISSUE_W];
    logic             t_cv  [COMMIT_W];
    logic [TAG_W-1:0] t_ctag[COMMIT_W];
    logic [RW-1:0]    t_crd [COMMIT_W];
    logic [XLEN-1:0]  t_cdat[COMMIT_W];
    logic             t_rb;

    // Reference model
    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    logic             m_err;

    int n_tests;
    int n_fail;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_stim();
        for (int j = 0; j < ISSUE_W; j++) begin
            t_dv[j] = 0; t_occ[j] = 0; t_rs1[j] = '0; t_rs2[j] = '0; t_rd[j] = '0; t_tag[j] = '0;
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            t_cv[k] = 0; t_ctag[k] = '0; t_crd[k] = '0; t_cdat[k] = '0;
        end
        t_rb = 0;
    endtask

    task automatic apply();
        for (int j = 0; j < ISSUE_W; j++) begin
            bus.dec_valid[j]              = t_dv[j];
            bus.dec_occupy_rd[j]          = t_occ[j];
            bus.dec_rs1[j*RW +: RW]       = t_rs1[j];
            bus.dec_rs2[j*RW +: RW]       = t_rs2[j];
            bus.dec_rd[j*RW +: RW]        = t_rd[j];
            bus.dec_tag[j*TAG_W +: TAG_W] = t_tag[j];
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            bus.cm_valid[k]              = t_cv[k];
            bus.cm_tag[k*TAG_W +: TAG_W] = t_ctag[k];
            bus.cm_rd[k*RW +: RW]        = t_crd[k];
            bus.cm_data[k*XLEN +: XLEN]  = t_cdat[k];
        end
        bus.rob_rollback = t_rb;
    endtask

    // Expected operand for slot j reading register rs
    task automatic model_read(input int j, input logic [RW-1:0] rs,
                              output logic [XLEN-1:0] v, output logic [TAG_W-1:0] q);
        v = '0;
        q = '0;
        if (rs != 0) begin
            if (m_busy[rs]) begin
                q = m_tag[rs];
`ifdef RRF_COMMIT_BYPASS_EN
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (t_cv[k] && t_ctag[k] == m_tag[rs]) begin
                        v = t_cdat[k];
                        q = '0;
                    end
                end
`endif
            end else begin
                v = m_val[rs];
            end
            for (int i = 0; i < j; i++) begin
                if (t_dv[i] && t_occ[i] && t_rd[i] == rs) begin
                    v = '0;
                    q = t_tag[i];
                end
            end
        end
    endtask

    // Mid-cycle: compare every output with the model
    task automatic eval();
        logic [XLEN-1:0]  v;
        logic [TAG_W-1:0] q;
        #4;
        for (int j = 0; j < ISSUE_W; j++) begin
            model_read(j, t_rs1[j], v, q);
            check_eq("vj", 64'(bus.dec_vj[j*XLEN +: XLEN]), 64'(v));
            check_eq("qj", 64'(bus.dec_qj[j*TAG_W +: TAG_W]), 64'(q));
            model_read(j, t_rs2[j], v, q);
            check_eq("vk", 64'(bus.dec_vk[j*XLEN +: XLEN]), 64'(v));
            check_eq("qk", 64'(bus.dec_qk[j*TAG_W +: TAG_W]), 64'(q));
        end
        check_eq("err_commit_idle", 64'(bus.err_commit_idle), 64'(m_err));
    endtask

    // Advance model and clock, resolving each register independently
    task automatic tick();
        bit               has_cm, match, has_rn;
        logic [XLEN-1:0]  cdat;
        logic [TAG_W-1:0] rtag;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_val[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
            end
            m_err = 0;
        end else if (t_rb) begin
            for (int r = 0; r < NREG; r++) begin
                m_busy[r] = 0; m_tag[r] = '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                has_cm = 0; match = 0; has_rn = 0; cdat = '0; rtag = '0;
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (t_cv[k] && int'(t_crd[k]) == r) begin
                        has_cm = 1;
                        cdat   = t_cdat[k];
                        if (t_ctag[k] == m_tag[r]) match = 1;
                    end
                end
                for (int j = 0; j < ISSUE_W; j++) begin
                    if (t_dv[j] && t_occ[j] && int'(t_rd[j]) == r) begin
                        has_rn = 1;
                        rtag   = t_tag[j];
                    end
                end
                if (has_cm && !m_busy[r]) m_err = 1;
                if (has_cm && m_busy[r]) m_val[r] = cdat;
                if (has_rn) begin
                    m_busy[r] = 1;
                    m_tag[r]  = rtag;
                end else if (has_cm && m_busy[r] && match) begin
                    m_busy[r] = 0;
                    m_tag[r]  = '0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ren(input int j, input int rd, input int tag);
        t_dv[j] = 1; t_occ[j] = 1; t_rd[j] = RW'(rd); t_tag[j] = TAG_W'(tag);
    endtask

    task automatic cmt(input int k, input int rd, input int tag, input int data);
        t_cv[k] = 1; t_crd[k] = RW'(rd); t_ctag[k] = TAG_W'(tag); t_cdat[k] = XLEN'(data);
    endtask

    task automatic rnd_cycle();
        int busy_q[$];
        clear_stim();
        for (int r = 1; r < NREG; r++) if (m_busy[r]) busy_q.push_back(r);
        for (int j = 0; j < ISSUE_W; j++) begin
            t_dv[j]  = ($urandom_range(0, 3) != 0);
            t_occ[j] = $urandom_range(0, 1) == 1;
            t_rs1[j] = RW'($urandom_range(0, 7));
            t_rs2[j] = RW'($urandom_range(0, 7));
            t_rd[j]  = RW'($urandom_range(0, 7));
            t_tag[j] = TAG_W'($urandom_range(1, 15));
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            t_cv[k]   = $urandom_range(0, 1) == 1;
            t_cdat[k] = XLEN'($urandom);
            if (busy_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                t_crd[k]  = RW'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
                t_ctag[k] = ($urandom_range(0, 3) != 0) ? m_tag[t_crd[k]]
                                                         : TAG_W'($urandom_range(1, 15));
            end else begin
                t_crd[k]  = RW'($urandom_range(0, 7));
                t_ctag[k] = TAG_W'($urandom_range(1, 15));
            end
        end
        t_rb = ($urandom_range(0, 19) == 0);
        apply();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_err   = 0;
        for (int r = 0; r < NREG; r++) begin
            m_val[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
        end
        clear_stim();
        apply();
        rst = 1;
        tick();
        rst = 0;

        // Reset state and idle commit to x5
        t_rs1[0] = 5; apply(); eval();
        check_eq("reset_vj5", 64'(bus.dec_vj[0 +: XLEN]), 64'h0);
        check_eq("reset_qj5", 64'(bus.dec_qj[0 +: TAG_W]), 64'h0);
        check_eq("reset_err", 64'(bus.err_commit_idle), 64'h0);
        clear_stim(); cmt(0, 5, 1, 'h55); apply(); eval(); tick();
        clear_stim(); apply(); eval();
        check_eq("err_set", 64'(bus.err_commit_idle), 64'h1);
        tick();

        // Rename x3 tag 2 in slot0, slot1 reads it same cycle
        clear_stim(); ren(0, 3, 2); t_dv[1] = 1; t_rs1[1] = 3; apply(); eval();
        check_eq("fwd_qj", 64'(bus.dec_qj[TAG_W +: TAG_W]), 64'h2);
        check_eq("fwd_vj", 64'(bus.dec_vj[XLEN +: XLEN]), 64'h0);
        tick();
        clear_stim(); t_rs1[0] = 3; apply(); eval();
        check_eq("table_qj3", 64'(bus.dec_qj[0 +: TAG_W]), 64'h2);
        tick();

        // x7 tag 4 then tag 6; stale commit keeps it busy
        clear_stim(); ren(0, 7, 4); apply(); eval(); tick();
        clear_stim(); ren(0, 7, 6); apply(); eval(); tick();
        clear_stim(); cmt(0, 7, 4, 'h11); apply(); eval(); tick();
        clear_stim(); t_rs1[0] = 7; apply(); eval();
        check_eq("x7_still_busy", 64'(bus.dec_qj[0 +: TAG_W]), 64'h6);
        tick();
        clear_stim(); cmt(0, 7, 6, 'h22); apply(); eval(); tick();
        clear_stim(); t_rs1[0] = 7; apply(); eval();
        check_eq("x7_qj", 64'(bus.dec_qj[0 +: TAG_W]), 64'h0);
        check_eq("x7_vj", 64'(bus.dec_vj[0 +: XLEN]), 64'h22);
        tick();

        // Commit x9 tag 3 with same-cycle rename x9 tag 5
        clear_stim(); ren(0, 9, 3); apply(); eval(); tick();
        clear_stim(); cmt(0, 9, 3, 'h99); ren(0, 9, 5); apply(); eval(); tick();
        clear_stim(); t_rs2[1] = 9; apply(); eval();
        check_eq("x9_qk", 64'(bus.dec_qk[TAG_W +: TAG_W]), 64'h5);
        tick();
        clear_stim(); t_rb = 1; apply(); eval(); tick();
        clear_stim(); t_rs2[1] = 9; apply(); eval();
        check_eq("x9_value", 64'(bus.dec_vk[XLEN +: XLEN]), 64'h99);
        tick();

        // Rollback with simultaneous commit to x1
        clear_stim(); ren(0, 1, 7); ren(1, 2, 8); apply(); eval(); tick();
        clear_stim(); t_rb = 1; cmt(0, 1, 7, 'hEE); apply(); eval(); tick();
        clear_stim(); t_rs1[0] = 1; t_rs2[0] = 2; apply(); eval();
        check_eq("rb_x1_v", 64'(bus.dec_vj[0 +: XLEN]), 64'h0);
        check_eq("rb_x1_q", 64'(bus.dec_qj[0 +: TAG_W]), 64'h0);
        check_eq("rb_x2_q", 64'(bus.dec_qk[0 +: TAG_W]), 64'h0);
        tick();

        // Busy x4 read while its producer commits
        clear_stim(); ren(0, 4, 1); apply(); eval(); tick();
        clear_stim(); t_rs2[0] = 4; cmt(0, 4, 1, 'hAB); apply(); eval();
`ifdef RRF_COMMIT_BYPASS_EN
        check_eq("bypass_vk", 64'(bus.dec_vk[0 +: XLEN]), 64'hAB);
        check_eq("bypass_qk", 64'(bus.dec_qk[0 +: TAG_W]), 64'h0);
`else
        check_eq("nobypass_vk", 64'(bus.dec_vk[0 +: XLEN]), 64'h0);
        check_eq("nobypass_qk", 64'(bus.dec_qk[0 +: TAG_W]), 64'h1);
`endif
        tick();
        clear_stim(); t_rs2[0] = 4; apply(); eval();
        check_eq("x4_after", 64'(bus.dec_vk[0 +: XLEN]), 64'hAB);
        tick();

        // Random traffic with one mid-run reset
        for (int c = 0; c < 400; c++) begin
            rnd_cycle();
            if (c == 200) begin
                rst = 1;
                eval();
                tick();
                rst = 0;
                clear_stim(); apply(); eval();
                check_eq("err_cleared", 64'(bus.err_commit_idle), 64'h0);
                tick();
            end else begin
                eval();
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
